// File: rtl/barrel_pkg.sv
// Shared helpers for the rotate-left encoder and rotate-right decoder barrel units.
// Rotation helpers work on words up to MAX_DATA_W bits; callers zero-extend narrower words.
package barrel_pkg;

  localparam int MAX_DATA_W = 64;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_DATA_W:0]   wide_t;

  function automatic int sa_width(input int data_width);
    return (data_width <= 2) ? 1 : $clog2(data_width);
  endfunction

  function automatic int bits_per_stage(input int sa_w, input int num_stages);
    return (sa_w + num_stages - 1) / num_stages;
  endfunction

  // Slice of the full shift amount owned by one stage, kept at its binary weight.
  function automatic int unsigned stage_shift(input int unsigned shift, input int stage_idx,
                                              input int bps, input int sa_w);
    int lo;
    int w;
    lo = stage_idx * bps;
    if (lo >= sa_w) return 0;
    w = ((sa_w - lo) < bps) ? (sa_w - lo) : bps;
    return ((shift >> lo) & ((32'd1 << w) - 32'd1)) << lo;
  endfunction

  // One extra bit of headroom keeps the shift by (width - 0) harmless when s = 0.
  function automatic word_t rot_right(input word_t x, input int width, input int unsigned s);
    wide_t wx;
    wide_t mask;
    wide_t r;
    wx   = {1'b0, x};
    mask = (wide_t'(1) << width) - wide_t'(1);
    r    = ((wx >> s) | (wx << (width - s))) & mask;
    return r[MAX_DATA_W-1:0];
  endfunction

  function automatic word_t rot_left(input word_t x, input int width, input int unsigned s);
    wide_t wx;
    wide_t mask;
    wide_t r;
    wx   = {1'b0, x};
    mask = (wide_t'(1) << width) - wide_t'(1);
    r    = ((wx << s) | (wx >> (width - s))) & mask;
    return r[MAX_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/barrel_rotr_stage.sv
// One valid/ready register stage of the rotate-right pipeline, resolving its shift slice.
// BARREL_ROTATOR_DIR_SEL_EN adds a carried direction bit (1 = rotate left).
module barrel_rotr_stage
  import barrel_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SA_WIDTH       = 5,
  parameter int BITS_PER_STAGE = 3,
  parameter int STAGE_IDX      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prev_valid,
  output logic                  prev_ready,
  input  logic [DATA_WIDTH-1:0] prev_data,
  input  logic [SA_WIDTH-1:0]   prev_shift,
`ifdef BARREL_ROTATOR_DIR_SEL_EN
  input  logic                  prev_dir,
  output logic                  dir,
`endif
  input  logic                  next_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [SA_WIDTH-1:0]   shift
);

  int unsigned           amt;
  word_t                 rot_word;
  logic [DATA_WIDTH-1:0] rot_data;

  always_comb begin
    amt = stage_shift(32'(prev_shift), STAGE_IDX, BITS_PER_STAGE, SA_WIDTH);
`ifdef BARREL_ROTATOR_DIR_SEL_EN
    if (prev_dir) rot_word = rot_left(word_t'(prev_data), DATA_WIDTH, amt);
    else          rot_word = rot_right(word_t'(prev_data), DATA_WIDTH, amt);
`else
    rot_word = rot_right(word_t'(prev_data), DATA_WIDTH, amt);
`endif
    rot_data = rot_word[DATA_WIDTH-1:0];
  end

  // Empty or draining stages accept; bubbles collapse.
  assign prev_ready = !valid || next_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      shift <= '0;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
      dir   <= 1'b0;
`endif
    end else if (prev_ready) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data  <= rot_data;
        shift <= prev_shift;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
        dir   <= prev_dir;
`endif
      end
    end
  end

endmodule

// File: rtl/barrel_rotator_rx.sv
// Pipelined rotate-right unit with per-word shift amount and valid/ready backpressure.
// BARREL_ROTATOR_DIR_SEL_EN adds in_dir/out_dir for per-word rotate direction.
module barrel_rotator_rx
  import barrel_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int NUM_STAGES     = 2,
  localparam int SA_WIDTH       = sa_width(DATA_WIDTH),
  localparam int BITS_PER_STAGE = bits_per_stage(SA_WIDTH, NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SA_WIDTH-1:0]   in_shift,
`ifdef BARREL_ROTATOR_DIR_SEL_EN
  input  logic                  in_dir,
  output logic                  out_dir,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SA_WIDTH-1:0]   out_shift
);

  // Index 0 is the input side; index k+1 is the register output of stage k.
  logic                  vld_p [0:NUM_STAGES];
  logic                  rdy_p [0:NUM_STAGES];
  logic [DATA_WIDTH-1:0] dat_p [0:NUM_STAGES];
  logic [SA_WIDTH-1:0]   sft_p [0:NUM_STAGES];
`ifdef BARREL_ROTATOR_DIR_SEL_EN
  logic                  dir_p [0:NUM_STAGES];
`endif

  assign vld_p[0]          = in_valid;
  assign dat_p[0]          = in_data;
  assign sft_p[0]          = in_shift;
  assign rdy_p[NUM_STAGES] = out_ready;
  assign in_ready          = rdy_p[0];
`ifdef BARREL_ROTATOR_DIR_SEL_EN
  assign dir_p[0]          = in_dir;
  assign out_dir           = dir_p[NUM_STAGES];
`endif

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    barrel_rotr_stage #(
      .DATA_WIDTH    (DATA_WIDTH),
      .SA_WIDTH      (SA_WIDTH),
      .BITS_PER_STAGE(BITS_PER_STAGE),
      .STAGE_IDX     (k)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .prev_valid(vld_p[k]),
      .prev_ready(rdy_p[k]),
      .prev_data (dat_p[k]),
      .prev_shift(sft_p[k]),
`ifdef BARREL_ROTATOR_DIR_SEL_EN
      .prev_dir  (dir_p[k]),
      .dir       (dir_p[k+1]),
`endif
      .next_ready(rdy_p[k+1]),
      .valid     (vld_p[k+1]),
      .data      (dat_p[k+1]),
      .shift     (sft_p[k+1])
    );
  end

  assign out_valid = vld_p[NUM_STAGES];
  assign out_data  = dat_p[NUM_STAGES];
  assign out_shift = sft_p[NUM_STAGES];

endmodule

// File: doc/barrel_rotator_rx.md
Name: barrel_rotator_rx

Overview:
- Pipelined rotate-right unit: the inverse of the team's pipelined rotate-left barrel shifter.
- Restores words rotated left by a known amount, e.g. decode/unscramble paths fed by the rotate-left encoder.
- Unlike the encoder, each word carries its own shift amount down the pipeline, with valid/ready flow control and per-stage backpressure.

Parameters:
- DATA_WIDTH, 32, word width; power of two, >= 2.
- NUM_STAGES, 2, register stages; 1..SA_WIDTH.
- SA_WIDTH (localparam), $clog2(DATA_WIDTH), shift-amount width.
- BITS_PER_STAGE (localparam), ceil(SA_WIDTH/NUM_STAGES), shift bits resolved per stage.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage 0 can accept.
- in_data  in  DATA_WIDTH  word to rotate right.
- in_shift  in  SA_WIDTH  right-rotate amount for this word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  in_data rotated right by in_shift.
- out_shift  out  SA_WIDTH  the shift amount that travelled with the word.

Behaviour:
- Stage k holds valid_k, data_k and shift_k (the full amount, carried along).
  - Stage k rotates right by shift bits [k*BPS +: BPS] placed back at weight 2^(k*BPS).
  - A stage whose slice starts at or beyond SA_WIDTH rotates by 0.
  - The last slice is truncated at SA_WIDTH-1.
- Rotation is (x >> s) | (x << (DATA_WIDTH - s)), computed DATA_WIDTH+1 bits wide so that s=0 returns x unchanged (no full-width shift hazard).
- Stage k advances when !valid_k or ready_{k+1}; ready_{NUM_STAGES} = out_ready. Bubbles collapse.
- in_ready = ready_0 (combinational through the chain; no registered skid).
- Transfer occurs on valid && ready on each side.
- Latency: NUM_STAGES cycles from input transfer to out_valid, with no backpressure. Throughput: 1 word/cycle.
- Outputs are the last-stage registers. Under backpressure, out_data/out_shift hold stable while out_valid && !out_ready.
- Order is strictly preserved; no word is dropped or duplicated.
- Simultaneous input accept and output pop in the same cycle are both honoured.
- Reset (sync, active-high, any time incl. mid-stream):
  - All valid_k = 0, data_k = 0, shift_k = 0.
  - out_valid = 0, out_data = 0, out_shift = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - In-flight words are discarded.
- in_data/in_shift are don't-care when in_valid = 0; they are not captured into valid state.

Optional Feature:
- Macro BARREL_ROTATOR_DIR_SEL_EN.
- Defined:
  - Adds port in_dir (in, 1); 0 = rotate right, 1 = rotate left.
  - A dir_k bit is carried per stage alongside shift_k.
  - Adds out_dir (out, 1), reset 0.
- Undefined: no in_dir/out_dir ports; direction is always right; no dir registers.

Decomposition:
- Package barrel_pkg:
  - rot_right and rot_left functions (width-generic via parameterised class or DATA_WIDTH-sized args).
  - Stage-slice helper returning the per-stage shift amount.
  - Shared localparam formulas for SA_WIDTH and BITS_PER_STAGE, so encoder and this block agree.
- Sub-module barrel_rotr_stage: one valid/ready register stage with a STAGE_IDX parameter; instantiated NUM_STAGES times by generate.

Test Plan:
- DATA_WIDTH=32, NUM_STAGES=2, out_ready=1; in_data=0x80000001, shift=1 -> 2 cycles later out_data=0xC0000000, out_shift=1.
- shift=0, in_data=0xDEADBEEF -> 0xDEADBEEF; shift=31, in_data=0x00000001 -> 0x00000002; shift=16, 0x1234ABCD -> 0xABCD1234.
- Backpressure: 4 back-to-back words, out_ready=0 for cycles 3-6.
  - in_ready drops once both stages fill.
  - Outputs hold stable.
  - All 4 words emerge in order; none lost.
- Reset asserted with 2 words in flight -> next cycle out_valid=0, out_data=0; words never appear; after reset, a fresh word has 2-cycle latency.
- Round trip: random data/shift through the rotate-left shifter (NUM_STAGES=3) into this block (NUM_STAGES=1, 3, 5) -> out_data equals the original word for 10k samples.
- With BARREL_ROTATOR_DIR_SEL_EN: in_dir=1, 0x00000001, shift=4 -> 0x00000010; in_dir=0 with the same data and shift -> 0x10000000.
